control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port instr, input, 16 bits: instruction word, where [15:12] is the opcode, [11:8] is dst, [7:4] is A, [3:0] is B, and [7:0] is the immediate when the opcode is LDI.
REQ-004 SHALL have port instr_valid, input, 1 bit: the upstream source is presenting instr.
REQ-005 SHALL have port instr_ready, output, 1 bit: control_unit accepts instr this cycle.
REQ-006 SHALL have port writeEnable, output, 1 bit: register-file write strobe to the datapath.
REQ-007 SHALL have port muxSel, output, 1 bit: 1 selects inputData, 0 selects the ALU result.
REQ-008 SHALL have port inputData, output, 8 bits: immediate value to the datapath.
REQ-009 SHALL have port dstSel, output, 4 bits: destination register select.
REQ-010 SHALL have port A_sel, output, 4 bits: ALU operand A register select.
REQ-011 SHALL have port B_sel, output, 4 bits: ALU operand B register select.
REQ-012 SHALL have port OP_Sel, output, 4 bits: ALU operation select.
REQ-013 SHALL have port busy, output, 1 bit: an instruction is in flight.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when an instruction retires.
REQ-015 SHALL have port illegal, output, 1 bit: one-cycle pulse when an unsupported opcode is dropped.
REQ-016 SHALL have port instr_count, output, 16 bits: count of retired instructions (see Configuration).

Function
REQ-017 Opcodes SHALL be: 0000 ZERO; 0100 ADD; 0101 NEG (two's complement of A); 0110 AND; 0111 OR; 1000 EQ; 1001 GT; 1111 LDI; 0001 NOP. All other opcodes are illegal.
REQ-018 The FSM SHALL have exactly the states IDLE, DECODE, EXEC, WRITE, and the state encoding SHALL be internal.
REQ-019 In IDLE, instr_ready SHALL be 1; in every other state it SHALL be 0.
REQ-020 When instr_valid=1 and instr_ready=1 on a clock edge, instr SHALL be latched into an internal register and the FSM SHALL go to DECODE.
REQ-021 In IDLE with instr_valid=0, the FSM SHALL stay in IDLE, and instr SHALL be ignored.
REQ-022 DECODE SHALL drive dstSel, A_sel, B_sel and OP_Sel from the latched word and SHALL go to EXEC, with these rules:
- LDI: muxSel=1, inputData=imm, OP_Sel=0000.
- ALU ops: muxSel=0, inputData=0.
REQ-023 EXEC SHALL hold every select stable for one cycle (ALU settle) and SHALL go to WRITE.
REQ-024 WRITE SHALL assert writeEnable=1 for exactly one cycle with all selects unchanged, SHALL pulse done=1 in the same cycle, and SHALL return to IDLE.
REQ-025 NOP SHALL traverse every state with writeEnable held 0 in WRITE, and SHALL still pulse done.
REQ-026 An illegal opcode SHALL pulse illegal=1 in DECODE and SHALL return to IDLE without asserting writeEnable or done.
REQ-027 Latency from accept edge N SHALL be: DECODE at N+1, EXEC at N+2, WRITE at N+3, and instr_ready=1 again at N+4.
REQ-028 busy SHALL equal (state != IDLE).
REQ-029 Selects SHALL change only on the transition into DECODE, so they are never modified while writeEnable=1.
REQ-030 instr_valid and instr changes while busy SHALL have no effect.

Reset
REQ-031 While reset=1, the FSM SHALL be forced to IDLE and all outputs SHALL be 0, except instr_ready=0.
REQ-032 On the first cycle after reset deasserts, instr_ready SHALL be 1.
REQ-033 Reset asserted in any state SHALL discard the in-flight instruction, with no writeEnable and no done.
REQ-034 Reset SHALL clear instr_count to 0.

Configuration
REQ-035 The macro CTRL_INSTR_COUNT_EN SHALL control the instr_count logic.
- Defined: instr_count SHALL increment by 1 (mod 2^16, wrapping 0xFFFF to 0x0000) on every done pulse.
- Undefined: instr_count SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-036 LDI scenario: reset, then send instr=0xF32A with valid held 1 -> at N+3, writeEnable=1, muxSel=1, dstSel=3, inputData=0x2A, done=1.
REQ-037 ADD scenario: send instr=0x4F01 -> at N+3, writeEnable=1, muxSel=0, OP_Sel=0100, dstSel=F, A_sel=0, B_sel=1.
REQ-038 Back-to-back scenario: hold valid with two words -> the second word is accepted at N+4, instr_ready=0 during N+1..N+3, and the word held during busy is not accepted.
REQ-039 Illegal/NOP scenario:
- Send 0x2123 -> illegal pulse at N+1, no writeEnable, next accept at N+2.
- Send 0x1000 -> done pulses, writeEnable stays 0.
REQ-040 Reset scenario: assert reset during EXEC of 0x6845 -> writeEnable is never 1, all outputs are 0, and instr_ready=1 one cycle after release.
REQ-041 Counter scenario (CTRL_INSTR_COUNT_EN defined): preload near wrap, retire 3 instructions from 0xFFFE -> instr_count reads 0x0001; with the macro undefined, instr_count stays 0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: four-state sequencer (IDLE -> DECODE -> EXEC -> WRITE) that
// accepts one 16-bit instruction at a time over a valid/ready handshake and
// drives the register-file/ALU selects of the datapath.
// Optional feature: define CTRL_INSTR_COUNT_EN to build the 16-bit counter of
// retired instructions; without it instr_count is tied to zero.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        writeEnable,
    output logic        muxSel,
    output logic [7:0]  inputData,
    output logic [3:0]  dstSel,
    output logic [3:0]  A_sel,
    output logic [3:0]  B_sel,
    output logic [3:0]  OP_Sel,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam logic [3:0] opZero = 4'b0000;
    localparam logic [3:0] opNop  = 4'b0001;
    localparam logic [3:0] opAdd  = 4'b0100;
    localparam logic [3:0] opNeg  = 4'b0101;
    localparam logic [3:0] opAnd  = 4'b0110;
    localparam logic [3:0] opOr   = 4'b0111;
    localparam logic [3:0] opEq   = 4'b1000;
    localparam logic [3:0] opGt   = 4'b1001;
    localparam logic [3:0] opLdi  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WRITE
    } stateT;

    stateT       state;
    stateT       nextState;

    logic [3:0]  curOp;
    logic        opLegal;
    logic        acceptComb;
    logic        readyComb;
    logic        writeComb;
    logic        doneComb;
    logic        illegalComb;

    logic        muxSelReg;
    logic [7:0]  inputDataReg;
    logic [3:0]  dstReg;
    logic [3:0]  aReg;
    logic [3:0]  bReg;
    logic [3:0]  opSelReg;

    // State register; reset discards whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Classify the latched opcode as supported or not.
    always_comb begin
        opLegal = 1'b0;
        if (curOp inside {opZero, opNop, opAdd, opNeg, opAnd, opOr, opEq, opGt, opLdi}) begin
            opLegal = 1'b1;
        end
    end

    // Next-state logic and per-state strobes; a NOP walks every state but never writes.
    always_comb begin
        nextState   = state;
        acceptComb  = 1'b0;
        readyComb   = 1'b0;
        writeComb   = 1'b0;
        doneComb    = 1'b0;
        illegalComb = 1'b0;
        unique case (state)
            IDLE: begin
                readyComb = 1'b1;
                if (instr_valid) begin
                    acceptComb = 1'b1;
                    nextState  = DECODE;
                end
            end
            DECODE: begin
                if (opLegal) begin
                    nextState = EXEC;
                end else begin
                    illegalComb = 1'b1;
                    nextState   = IDLE;
                end
            end
            EXEC: begin
                nextState = WRITE;
            end
            WRITE: begin
                doneComb  = 1'b1;
                writeComb = (curOp != opNop);
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Latch the instruction and its decoded selects on the accept edge only, so
    // the selects are valid from DECODE onward and frozen through WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            curOp        <= 4'h0;
            muxSelReg    <= 1'b0;
            inputDataReg <= 8'h00;
            dstReg       <= 4'h0;
            aReg         <= 4'h0;
            bReg         <= 4'h0;
            opSelReg     <= 4'h0;
        end else if (acceptComb) begin
            curOp  <= instr[15:12];
            dstReg <= instr[11:8];
            aReg   <= instr[7:4];
            bReg   <= instr[3:0];
            if (instr[15:12] == opLdi) begin
                muxSelReg    <= 1'b1;
                inputDataReg <= instr[7:0];
                opSelReg     <= 4'h0;
            end else begin
                muxSelReg    <= 1'b0;
                inputDataReg <= 8'h00;
                opSelReg     <= instr[15:12];
            end
        end
    end

    // Outputs are forced low while reset is high, including instr_ready.
    assign instr_ready = readyComb & ~reset;
    assign writeEnable = writeComb & ~reset;
    assign done        = doneComb & ~reset;
    assign illegal     = illegalComb & ~reset;
    assign busy        = (state != IDLE) & ~reset;
    assign muxSel      = muxSelReg & ~reset;
    assign inputData   = reset ? 8'h00 : inputDataReg;
    assign dstSel      = reset ? 4'h0 : dstReg;
    assign A_sel       = reset ? 4'h0 : aReg;
    assign B_sel       = reset ? 4'h0 : bReg;
    assign OP_Sel      = reset ? 4'h0 : opSelReg;

`ifdef CTRL_INSTR_COUNT_EN
    logic [15:0] instrCount;

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            instrCount <= 16'h0000;
        end else if (doneComb) begin
            instrCount <= instrCount + 16'd1;
        end
    end

    assign instr_count = reset ? 16'h0000 : instrCount;
`else
    assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard-driven bench for control_unit. Expected decode
// results are queued when a word is offered and popped when it retires.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        writeEnable;
    logic        muxSel;
    logic [7:0]  inputData;
    logic [3:0]  dstSel;
    logic [3:0]  A_sel;
    logic [3:0]  B_sel;
    logic [3:0]  OP_Sel;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] instr_count;

    int checks = 0;
    int fails  = 0;
    int weCount = 0;
    int doneCount = 0;

    typedef struct {
        logic       isIllegal;
        logic       we;
        logic       mux;
        logic [7:0] data;
        logic [3:0] dst;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        int         latency;
    } expT;

    expT sb[$];

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .writeEnable (writeEnable),
        .muxSel      (muxSel),
        .inputData   (inputData),
        .dstSel      (dstSel),
        .A_sel       (A_sel),
        .B_sel       (B_sel),
        .OP_Sel      (OP_Sel),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Tally every write strobe and done pulse seen on the outputs.
    always @(negedge clk) begin
        if (writeEnable) weCount++;
        if (done) doneCount++;
    end

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decode of one instruction word.
    function automatic expT modelDecode(input logic [15:0] w);
        expT e;
        logic [3:0] op;
        op          = w[15:12];
        e.isIllegal = !(op inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF});
        e.we        = !e.isIllegal && (op != 4'h1);
        e.mux       = (op == 4'hF);
        e.data      = (op == 4'hF) ? w[7:0] : 8'h00;
        e.op        = (op == 4'hF) ? 4'h0 : op;
        e.dst       = w[11:8];
        e.a         = w[7:4];
        e.b         = w[3:0];
        e.latency   = e.isIllegal ? 1 : 3;
        return e;
    endfunction

    // Offer a word in the current (low-phase) cycle and advance to the cycle after the accept edge.
    task automatic applyStimulus(input logic [15:0] w, input bit hold, output bit wasReady);
        instr       = w;
        instr_valid = 1'b1;
        #1;
        wasReady = instr_ready;
        sb.push_back(modelDecode(w));
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
    endtask

    // Wait (bounded) for the in-flight word to retire or be dropped; lat counts cycles after accept.
    task automatic waitRetire(output int lat, output bit timedOut);
        lat      = 1;
        timedOut = 1'b0;
        while (!(done || illegal)) begin
            if (lat >= 8) begin
                timedOut = 1'b1;
                return;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [50:0] allOut;
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'hF0FF;
        repeat (3) @(negedge clk);
        allOut = {instr_ready, writeEnable, muxSel, inputData, dstSel, A_sel, B_sel,
                  OP_Sel, busy, done, illegal, instr_count};
        checks++;
        if (allOut !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", allOut);
        end
        reset       = 1'b0;
        instr_valid = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", instr_ready);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_ldi();
        bit  rdy;
        bit  tmo;
        int  lat;
        expT e;
        sb.delete();
        applyStimulus(16'hF32A, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ldi_ready: got %b expected 1", rdy);
        end
        checks++;
        if ({instr_ready, busy} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL ldi_decode_handshake: got ready/busy %b expected 01", {instr_ready, busy});
        end
        waitRetire(lat, tmo);
        e = sb.pop_front();
        checks++;
        if (tmo || lat != e.latency) begin
            fails++;
            $display("[TB] FAIL ldi_latency: got %0d (timeout %0b) expected %0d", lat, tmo, e.latency);
        end
        checks++;
        if ({writeEnable, done, muxSel, dstSel, inputData, OP_Sel} !== {e.we, 1'b1, e.mux, e.dst, e.data, e.op}) begin
            fails++;
            $display("[TB] FAIL ldi_write: got we=%b done=%b mux=%b dst=%h data=%h op=%h expected we=%b done=1 mux=%b dst=%h data=%h op=%h",
                     writeEnable, done, muxSel, dstSel, inputData, OP_Sel, e.we, e.mux, e.dst, e.data, e.op);
        end
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({instr_ready, writeEnable, done} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL ldi_return_idle: got ready/we/done %b expected 100", {instr_ready, writeEnable, done});
        end
    endtask

    task automatic test_alu_ops();
        logic [15:0] words [7] = '{16'h4F01, 16'h5230, 16'h6845, 16'h7ABC, 16'h8123, 16'h9456, 16'h0777};
        bit  rdy;
        bit  tmo;
        int  lat;
        expT e;
        sb.delete();
        foreach (words[i]) begin
            applyStimulus(words[i], 1'b0, rdy);
            waitRetire(lat, tmo);
            e = sb.pop_front();
            checks++;
            if (!rdy || tmo || lat != e.latency) begin
                fails++;
                $display("[TB] FAIL alu_latency[%h]: got ready=%b lat=%0d timeout=%b expected ready=1 lat=%0d",
                         words[i], rdy, lat, tmo, e.latency);
            end
            checks++;
            if ({writeEnable, done, muxSel, inputData, OP_Sel, dstSel, A_sel, B_sel} !==
                {e.we, 1'b1, e.mux, e.data, e.op, e.dst, e.a, e.b}) begin
                fails++;
                $display("[TB] FAIL alu_write[%h]: got we=%b done=%b mux=%b data=%h op=%h dst=%h a=%h b=%h expected we=%b done=1 mux=%b data=%h op=%h dst=%h a=%h b=%h",
                         words[i], writeEnable, done, muxSel, inputData, OP_Sel, dstSel, A_sel, B_sel,
                         e.we, e.mux, e.data, e.op, e.dst, e.a, e.b);
            end
            @(negedge clk);
            checks++;
            if ({writeEnable, done, instr_ready} !== 3'b001) begin
                fails++;
                $display("[TB] FAIL alu_single_pulse[%h]: got we/done/ready %b expected 001", words[i], {writeEnable, done, instr_ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        bit  rdy;
        bit  tmo;
        int  lat;
        int  readyHigh;
        expT e;
        sb.delete();
        readyHigh = 0;
        applyStimulus(16'h4123, 1'b1, rdy);
        instr = 16'h7456;
        for (int k = 1; k <= 3; k++) begin
            if (instr_ready) readyHigh++;
            if (k < 3) @(negedge clk);
        end
        checks++;
        if (!rdy || readyHigh != 0) begin
            fails++;
            $display("[TB] FAIL b2b_ready_busy: got first-accept=%b ready-high-cycles=%0d expected 1 and 0", rdy, readyHigh);
        end
        e = sb.pop_front();
        checks++;
        if ({done, writeEnable, dstSel, A_sel, B_sel, OP_Sel} !== {1'b1, e.we, e.dst, e.a, e.b, e.op}) begin
            fails++;
            $display("[TB] FAIL b2b_first_write: got done=%b we=%b dst=%h a=%h b=%h op=%h expected done=1 we=%b dst=%h a=%h b=%h op=%h",
                     done, writeEnable, dstSel, A_sel, B_sel, OP_Sel, e.we, e.dst, e.a, e.b, e.op);
        end
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_ready_n4: got %b expected 1", instr_ready);
        end
        sb.push_back(modelDecode(16'h7456));
        @(negedge clk);
        instr_valid = 1'b0;
        waitRetire(lat, tmo);
        e = sb.pop_front();
        checks++;
        if (tmo || lat != e.latency || {writeEnable, dstSel, A_sel, B_sel, OP_Sel} !== {e.we, e.dst, e.a, e.b, e.op}) begin
            fails++;
            $display("[TB] FAIL b2b_second_write: got lat=%0d we=%b dst=%h a=%h b=%h op=%h expected lat=%0d we=%b dst=%h a=%h b=%h op=%h",
                     lat, writeEnable, dstSel, A_sel, B_sel, OP_Sel, e.latency, e.we, e.dst, e.a, e.b, e.op);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal_nop();
        bit  rdy;
        bit  tmo;
        int  lat;
        int  weStart;
        expT e;
        sb.delete();
        weStart = weCount;
        applyStimulus(16'h2123, 1'b0, rdy);
        waitRetire(lat, tmo);
        e = sb.pop_front();
        checks++;
        if (!rdy || tmo || lat != e.latency || {illegal, writeEnable, done} !== {e.isIllegal, 2'b00}) begin
            fails++;
            $display("[TB] FAIL illegal_pulse: got lat=%0d illegal=%b we=%b done=%b expected lat=%0d illegal=%b we=0 done=0",
                     lat, illegal, writeEnable, done, e.latency, e.isIllegal);
        end
        @(negedge clk);
        checks++;
        if ({instr_ready, illegal} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL illegal_reaccept: got ready/illegal %b expected 10", {instr_ready, illegal});
        end
        applyStimulus(16'h1000, 1'b0, rdy);
        waitRetire(lat, tmo);
        e = sb.pop_front();
        checks++;
        if (!rdy || tmo || lat != e.latency || {done, writeEnable, illegal} !== {1'b1, e.we, e.isIllegal}) begin
            fails++;
            $display("[TB] FAIL nop_retire: got lat=%0d done=%b we=%b illegal=%b expected lat=%0d done=1 we=%b illegal=%b",
                     lat, done, writeEnable, illegal, e.latency, e.we, e.isIllegal);
        end
        @(negedge clk);
        checks++;
        if (weCount != weStart) begin
            fails++;
            $display("[TB] FAIL illegal_nop_no_write: got %0d write strobes expected 0", weCount - weStart);
        end
    endtask

    task automatic test_reset_midflight();
        bit          rdy;
        int          weStart;
        int          doneStart;
        logic [50:0] allOut;
        sb.delete();
        weStart   = weCount;
        doneStart = doneCount;
        applyStimulus(16'h6845, 1'b0, rdy);
        @(negedge clk);
        checks++;
        if ({rdy, busy} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL midreset_in_exec: got accept/busy %b expected 11", {rdy, busy});
        end
        reset = 1'b1;
        void'(sb.pop_front());
        #1;
        allOut = {instr_ready, writeEnable, muxSel, inputData, dstSel, A_sel, B_sel,
                  OP_Sel, busy, done, illegal, instr_count};
        checks++;
        if (allOut !== '0) begin
            fails++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0", allOut);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({instr_ready, busy} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL midreset_release: got ready/busy %b expected 10", {instr_ready, busy});
        end
        repeat (4) @(negedge clk);
        checks++;
        if (weCount != weStart || doneCount != doneStart) begin
            fails++;
            $display("[TB] FAIL midreset_discard: got we=%0d done=%0d extra pulses expected 0 and 0",
                     weCount - weStart, doneCount - doneStart);
        end
    endtask

    task automatic test_counter();
        logic [15:0] modelCount;
        bit          rdy;
        bit          tmo;
        int          lat;
        expT         e;
        sb.delete();
`ifdef CTRL_INSTR_COUNT_EN
        force dut.instrCount = 16'hFFFE;
        #1;
        release dut.instrCount;
        modelCount = 16'hFFFE;
`else
        modelCount = 16'h0000;
`endif
        #1;
        checks++;
        if (instr_count !== modelCount) begin
            fails++;
            $display("[TB] FAIL count_start: got %h expected %h", instr_count, modelCount);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(16'h4000 + 16'(k), 1'b0, rdy);
            waitRetire(lat, tmo);
            e = sb.pop_front();
            checks++;
            if (!rdy || tmo || done !== 1'b1 || writeEnable !== e.we) begin
                fails++;
                $display("[TB] FAIL count_retire[%0d]: got ready=%b timeout=%b done=%b we=%b expected 1 0 1 %b",
                         k, rdy, tmo, done, writeEnable, e.we);
            end
            @(negedge clk);
`ifdef CTRL_INSTR_COUNT_EN
            modelCount = modelCount + 16'd1;
`endif
            checks++;
            if (instr_count !== modelCount) begin
                fails++;
                $display("[TB] FAIL count_value[%0d]: got %h expected %h", k, instr_count, modelCount);
            end
        end
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        reset       = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        @(negedge clk);
        $display("[TB] starting control_unit scenarios");
        test_reset();
        test_ldi();
        test_alu_ops();
        test_back_to_back();
        test_illegal_nop();
        test_reset_midflight();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
